// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues reads to a synchronous imem,
// buffers returned words with their PCs and hands them to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stop,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_inst_q [DEPTH];
    logic [31:0]   buf_inst_d [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_pc_d   [DEPTH];

    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // The in-flight word counts against the buffer so a capture can never overflow.
    always_comb begin
        occupancy = count_q + {{(CW-1){1'b0}}, rsp_valid_q};
        issue     = !i_redirect && (occupancy < DEPTH_C);
        push      = rsp_valid_q && !i_redirect;
        pop       = (count_q != '0) && i_inst_ready && !i_redirect;
    end

    always_comb begin
        pc_d        = pc_q;
        rsp_valid_d = 1'b0;
        rsp_pc_d    = rsp_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;

        if (i_redirect) begin
            pc_d     = {i_redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d        = pc_q + 32'd4;
                rsp_valid_d = 1'b1;
                rsp_pc_d    = pc_q;
            end
            if (push) begin
                buf_inst_d[wr_ptr_q] = i_imem_data;
                buf_pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= 32'h0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_inst_q[i] <= 32'h0;
                buf_pc_q[i]   <= 32'h0;
            end
        end else begin
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign o_imem_addr  = pc_q;
    assign o_imem_stop  = !issue;
    assign o_inst_valid = (count_q != '0);
    assign o_inst       = buf_inst_q[rd_ptr_q];
    assign o_inst_pc    = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, a monitor
// pops and compares every accepted instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic [31:0] o_imem_addr;
    logic        o_imem_stop;
    logic [31:0] i_imem_data = 32'h0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_addr  (o_imem_addr),
        .o_imem_stop  (o_imem_stop),
        .i_imem_data  (i_imem_data),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .i_inst_ready (i_inst_ready)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1234_5678;
    endfunction

    // Synchronous imem: output register updates only when not stopped.
    always @(posedge clk) begin
        if (!o_imem_stop) i_imem_data <= inst_of(o_imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic restart_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int n = 0;
        while (delivered < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (delivered < target) begin
            bad++;
            $display("FAIL wait_deliv: got %0d want %0d", delivered, target);
        end
    endtask

    // Redirect for one cycle; head shows the aligned target three cycles later.
    task automatic do_redirect(input logic [31:0] target, input logic [31:0] start);
        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        restart_exp(start);
        @(negedge clk);
        check("redir_stop", {31'h0, o_imem_stop}, 32'h1);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        check("redir_t1_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("redir_t2_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("redir_t3_valid", {31'h0, o_inst_valid}, 32'h1);
        check("redir_t3_pc", o_inst_pc, start);
    endtask

    always @(negedge clk) begin
        if (!rst && o_inst_valid && i_inst_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got pc %h want none", o_inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("mon_pc", o_inst_pc, e);
                check("mon_inst", o_inst, inst_of(e));
                delivered++;
            end
        end
    end

    initial begin
        logic [31:0] head;
        int d0;

        restart_exp(RESET_PC);
        #12;
        check("rst_addr", o_imem_addr, RESET_PC);
        check("rst_stop", {31'h0, o_imem_stop}, 32'h0);
        check("rst_valid", {31'h0, o_inst_valid}, 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_inst_pc", o_inst_pc, 32'h0);

        // Scenario 1: reset release with ready high
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("c0_addr", o_imem_addr, 32'h0);
        check("c0_stop", {31'h0, o_imem_stop}, 32'h0);
        @(negedge clk);
        check("c1_addr", o_imem_addr, 32'h4);
        check("c1_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("c2_addr", o_imem_addr, 32'h8);
        check("c2_valid", {31'h0, o_inst_valid}, 32'h1);
        check("c2_pc", o_inst_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stream_stop", {31'h0, o_imem_stop}, 32'h0);
        end
        wait_deliv(6, 20);

        // Scenario 2: backpressure fills the buffer
        @(posedge clk); #1;
        i_inst_ready = 1'b0;
        repeat (8) @(negedge clk);
        head = exp_q[0];
        check("bp_valid", {31'h0, o_inst_valid}, 32'h1);
        check("bp_stop", {31'h0, o_imem_stop}, 32'h1);
        check("bp_head_pc", o_inst_pc, head);
        check("bp_head_inst", o_inst, inst_of(head));
        @(posedge clk); #1;
        i_inst_ready = 1'b1;
        d0 = delivered;
        wait_deliv(d0 + 8, 30);

        // Scenario 3: redirect with 2 buffered and one in flight
        @(posedge clk); #1;
        i_inst_ready = 1'b0;
        @(posedge clk); #1;
        i_inst_ready = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        restart_exp(32'h0000_0100);
        @(negedge clk);
        check("s3_stop", {31'h0, o_imem_stop}, 32'h1);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        check("s3_t1_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("s3_t2_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("s3_t3_valid", {31'h0, o_inst_valid}, 32'h1);
        check("s3_t3_pc", o_inst_pc, 32'h0000_0100);
        d0 = delivered;
        wait_deliv(d0 + 4, 20);

        // Scenario 4: misaligned target, wrap, consecutive redirects
        do_redirect(32'h0000_0103, 32'h0000_0100);
        d0 = delivered;
        wait_deliv(d0 + 3, 20);
        do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_pc", o_inst_pc, 32'h0000_0000);
        d0 = delivered;
        wait_deliv(d0 + 3, 20);

        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0500;
        restart_exp(32'h0000_0500);
        @(posedge clk); #1;
        i_redirect_pc = 32'h0000_0300;
        restart_exp(32'h0000_0300);
        @(negedge clk);
        check("dbl_stop", {31'h0, o_imem_stop}, 32'h1);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        repeat (3) @(negedge clk);
        check("dbl_valid", {31'h0, o_inst_valid}, 32'h1);
        check("dbl_pc", o_inst_pc, 32'h0000_0300);
        d0 = delivered;
        wait_deliv(d0 + 4, 20);

        // Scenario 5: redirect while full and stalled, then random ready
        @(posedge clk); #1;
        i_inst_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("s5_full_stop", {31'h0, o_imem_stop}, 32'h1);
        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        restart_exp(32'h0000_0200);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        @(negedge clk);
        check("s5_t1_valid", {31'h0, o_inst_valid}, 32'h0);
        repeat (5) @(negedge clk);
        check("s5_refill_valid", {31'h0, o_inst_valid}, 32'h1);
        check("s5_refill_pc", o_inst_pc, 32'h0000_0200);
        check("s5_refill_stop", {31'h0, o_imem_stop}, 32'h1);
        d0 = delivered;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            i_inst_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        i_inst_ready = 1'b1;
        wait_deliv(d0 + 40, 100);

        // Scenario 6: asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1;
        restart_exp(RESET_PC);
        #1;
        check("arst_valid", {31'h0, o_inst_valid}, 32'h0);
        check("arst_addr", o_imem_addr, RESET_PC);
        rst = 1'b0;
        @(negedge clk);
        check("arst_c0_addr", o_imem_addr, 32'h0);
        check("arst_c0_stop", {31'h0, o_imem_stop}, 32'h0);
        check("arst_c0_valid", {31'h0, o_inst_valid}, 32'h0);
        @(negedge clk);
        check("arst_c1_addr", o_imem_addr, 32'h4);
        @(negedge clk);
        check("arst_c2_valid", {31'h0, o_inst_valid}, 32'h1);
        check("arst_c2_pc", o_inst_pc, 32'h0);
        d0 = delivered;
        wait_deliv(d0 + 5, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and drives the address and stop inputs of the synchronous instruction memory, which returns data one cycle after an unstalled address.
- Captures each returned word with its PC into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- DEPTH, 4, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_redirect  input  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  input  32  redirect target
- o_imem_addr  output  32  byte address to imem
- o_imem_stop  output  1  1 = imem holds its output register (no new read)
- i_imem_data  input  32  imem read data, valid the cycle after an issue
- o_inst_valid  output  1  buffer head valid
- o_inst  output  32  head instruction
- o_inst_pc  output  32  head instruction PC
- i_inst_ready  input  1  decode accepts head

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); all state clears immediately on assertion.
- Reset values:
  - pc = RESET_PC; rsp_valid = 0; count = 0; rd/wr pointers = 0; all buffer entries = 0.
  - Outputs: o_imem_addr = RESET_PC, o_imem_stop = 0, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0.
- o_imem_addr = pc (registered). Issue condition: issue = !i_redirect && (count + rsp_valid) < DEPTH. o_imem_stop = !issue (combinational).
- On issue: pc <= pc + 4 (32-bit modulo, 0xFFFFFFFC wraps to 0); rsp_valid <= 1; rsp_pc <= pc. Otherwise pc holds and rsp_valid <= 0.
- Response capture: when rsp_valid = 1, {i_imem_data, rsp_pc} is pushed into the FIFO in that same cycle. The credit check guarantees the push never overflows.
- Pop: when o_inst_valid && i_inst_ready, rd pointer advances.
  - Push and pop in the same cycle: count unchanged.
  - Pop on an empty buffer is ignored.
- o_inst_valid = (count != 0). o_inst and o_inst_pc come from the head entry and are registered-storage outputs (no combinational path from i_imem_data).
- Redirect (i_redirect = 1) has priority over push, pop and issue in that cycle:
  - count <= 0, pointers <= 0, rsp_valid <= 0 (the in-flight word is discarded).
  - pc <= {i_redirect_pc[31:2], 2'b00}.
  - o_imem_stop = 1 that cycle.
- Latency:
  - First issue in the first cycle after rst deasserts (cycle 0); data arrives cycle 1; o_inst_valid in cycle 2.
  - Redirect at T: target issued T+1, data T+2, valid at head T+3.
- Throughput: one instruction per cycle when i_inst_ready is held high.
- Backpressure: the buffer fills to exactly DEPTH. The imem is stopped once count + rsp_valid reaches DEPTH. No instruction is lost or duplicated.
- Redirect asserted on consecutive cycles: the last target wins; no issue occurs until i_redirect drops.
- Reset mid-operation: all state aborts immediately; fetch restarts at RESET_PC.

Test Plan:
1. Reset release, i_inst_ready = 1 → o_imem_addr 0, 4, 8, … in cycles 0, 1, 2. o_inst_valid rises in cycle 2 with o_inst_pc = 0, then pc 4, 8, … each cycle; o_imem_stop stays 0.
2. Streaming, then i_inst_ready = 0 for 8 cycles → count saturates at 4, o_imem_stop = 1, head held. On release, PCs continue exactly in sequence with no gap or repeat.
3. i_redirect = 1 with i_redirect_pc = 0x0000_0100 while a word is in flight and 2 entries are buffered → o_inst_valid = 0 next cycle; the next delivered o_inst_pc = 0x100 three cycles after the redirect; old PCs never appear.
4. Redirect to 0x0000_0103 → fetch starts at 0x100. Redirect to 0xFFFF_FFFC → delivered PCs 0xFFFF_FFFC, then 0x0000_0000.
5. Redirect while buffer full and i_inst_ready = 0 → buffer empties and refills from the target only; i_inst_ready toggled randomly afterwards still yields a strictly sequential PC stream.
6. rst pulsed asynchronously mid-stream (between clock edges) → o_inst_valid drops immediately, o_imem_addr = RESET_PC, and the stream restarts as in scenario 1.
